seq_div_i12_o12: RTL and testbench
==================================

SEQ_DIV_I12_O12 -- requirements
Module: seq_div_i12_o12

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updated on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-005 SHALL have port dividend, input, 12 bits: unsigned dividend.
REQ-006 SHALL have port divisor, input, 6 bits: unsigned divisor.
REQ-007 SHALL have port out_valid, output, 1 bit: result held on outputs.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-009 SHALL have port quotient, output, 12 bits: unsigned quotient.
REQ-010 SHALL have port remainder, output, 6 bits: unsigned remainder.
REQ-011 SHALL have port div_zero, output, 1 bit: the held result came from divisor==0.
REQ-012 SHALL have port busy, output, 1 bit: the block is in RUN.

Function
REQ-013 SHALL implement the inverse of the team's 6x6->12 unsigned multiplier: quotient*divisor+remainder==dividend, remainder<divisor, for every divisor!=0.
REQ-014 SHALL use restoring division, one quotient bit per cycle, MSB first, with a 7-bit partial remainder.
REQ-015 SHALL have FSM states IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, SHALL capture both operands, clear the iteration counter and go to RUN.
REQ-017 RUN: in_ready=0 and busy=1; after the 12th iteration SHALL go to DONE.
REQ-018 Latency: handshake at edge N -> iterations at edges N+1..N+12 -> out_valid=1 from edge N+12.
REQ-019 DONE: out_valid=1; quotient, remainder and div_zero SHALL stay stable until out_valid&out_ready.
REQ-020 On that edge SHALL go to IDLE; in_ready rises the cycle after (no same-cycle bypass, max throughput 1 op per 14 cycles).
REQ-021 in_valid while not in IDLE SHALL be ignored; operands are not sampled.
REQ-022 divisor==0 SHALL give quotient=12'hFFF, remainder=dividend[5:0], div_zero=1; all other results give div_zero=0.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs except none-required (in_ready, out_valid decode state only).
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE from any state, including mid-RUN and mid-DONE; the in-flight result is discarded.
REQ-026 After reset: in_ready=1, out_valid=0, busy=0, quotient=0, remainder=0, div_zero=0, counter=0.
REQ-027 A handshake in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-028 Macro SEQ_DIV_ZERO_FAST_EN SHALL select divide-by-zero latency.
REQ-029 With SEQ_DIV_ZERO_FAST_EN defined: divisor==0 skips RUN; go IDLE->DONE at edge N+1 with the REQ-022 result.
REQ-030 Without SEQ_DIV_ZERO_FAST_EN: divisor==0 runs the full 12 iterations (REQ-018 latency); the REQ-022 result arises from the normal datapath.
REQ-031 Result values SHALL be identical in both builds; only latency differs.

Verification
REQ-032 dividend=100, divisor=7, out_ready=1 -> out_valid 12 cycles after the handshake, quotient=14, remainder=2, div_zero=0.
REQ-033 dividend=4095, divisor=1 -> quotient=4095, remainder=0; then dividend=5, divisor=63 -> quotient=0, remainder=5.
REQ-034 dividend=12'hABC, divisor=0 -> quotient=12'hFFF, remainder=6'h3C, div_zero=1.
- Latency is 1 cycle with SEQ_DIV_ZERO_FAST_EN and 12 cycles without.
REQ-035 dividend=3000, divisor=45, out_ready held 0 for 5 cycles in DONE -> outputs stable at quotient=66, remainder=30.
- in_valid pulses during RUN/DONE are ignored.
- in_ready returns 1 the cycle after the out_ready handshake.
REQ-036 rst=1 at the 6th RUN cycle -> next cycle in_ready=1, out_valid=0, busy=0.
- A subsequent dividend=63, divisor=9 yields quotient=7, remainder=0.
REQ-037 Random sweep of all dividend/divisor pairs against the REQ-013 identity, with random out_ready backpressure -> zero mismatches.

Source files
------------

// File: rtl/seq_div_i12_o12.sv
// Sequential restoring divider: 12-bit dividend / 6-bit divisor, one quotient bit per cycle.
// Define SEQ_DIV_ZERO_FAST_EN to finish divide-by-zero after a single cycle instead of twelve.
module seq_div_i12_o12 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] dividend,
  input  logic [5:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] quotient,
  output logic [5:0]  remainder,
  output logic        div_zero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [11:0] dq;
  logic [5:0]  dvs;
  logic [5:0]  prem;
  logic [3:0]  count;

  logic [6:0]  shifted;
  logic        fits;
  logic [5:0]  next_rem;

  // A successful trial subtraction always leaves less than the divisor, so the low six bits suffice.
  always_comb begin
    shifted  = {prem, dq[11]};
    fits     = (shifted >= {1'b0, dvs});
    next_rem = fits ? (shifted[5:0] - dvs) : shifted[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      quotient  <= 12'd0;
      remainder <= 6'd0;
      div_zero  <= 1'b0;
      count     <= 4'd0;
      dq        <= 12'd0;
      dvs       <= 6'd0;
      prem      <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dq       <= dividend;
            dvs      <= divisor;
            prem     <= 6'd0;
            count    <= 4'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
`ifdef SEQ_DIV_ZERO_FAST_EN
          if (dvs == 6'd0) begin
            quotient  <= 12'hFFF;
            remainder <= dq[5:0];
            div_zero  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
`else
          begin
`endif
            // Dividend bits shift out the top while quotient bits shift in at the bottom.
            dq    <= {dq[10:0], fits};
            prem  <= next_rem;
            count <= count + 4'd1;
            if (count == 4'd11) begin
              quotient  <= {dq[10:0], fits};
              remainder <= next_rem;
              div_zero  <= (dvs == 6'd0);
              busy      <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_i12_o12.sv
// Randomised self-checking bench for seq_div_i12_o12 against an arithmetic reference model.
// Honours SEQ_DIV_ZERO_FAST_EN for the expected divide-by-zero latency.
module tb_seq_div_i12_o12;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        div_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 12;
`endif

  always #5 clk = ~clk;

  seq_div_i12_o12 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  function automatic logic [11:0] ref_q(input logic [11:0] a, input logic [5:0] b);
    return (b == 6'd0) ? 12'hFFF : a / {6'd0, b};
  endfunction

  function automatic logic [5:0] ref_r(input logic [11:0] a, input logic [5:0] b);
    logic [11:0] m;
    m = (b == 6'd0) ? {6'd0, a[5:0]} : a % {6'd0, b};
    return m[5:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [11:0] a, input logic [5:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    dividend = 12'd77; divisor = 6'd5;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (quotient !== 12'd0 || remainder !== 6'd0 || div_zero !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_result: got q=%0d r=%0d dz=%b expected 0 0 0", quotient, remainder, div_zero);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    offer(12'd100, 6'd7);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_run_flags: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    wait_result(lat);
    checks++; if (lat != 12) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 12", lat); end
    checks++; if (quotient !== 12'd14 || remainder !== 6'd2 || div_zero !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_result: got q=%0d r=%0d dz=%b expected 14 2 0", quotient, remainder, div_zero);
    end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_extremes();
    logic [11:0] a_tab [3] = '{12'd4095, 12'd5, 12'hABC};
    logic [5:0]  b_tab [3] = '{6'd1, 6'd63, 6'd0};
    logic [11:0] q_tab [3] = '{12'd4095, 12'd0, 12'hFFF};
    logic [5:0]  r_tab [3] = '{6'd0, 6'd5, 6'h3C};
    int lat;
    for (int i = 0; i < 3; i++) begin
      offer(a_tab[i], b_tab[i]);
      wait_result(lat);
      checks++; if (lat != ((b_tab[i] == 6'd0) ? ZLAT : 12)) begin
        errors++; $display("[TB] FAIL extreme_latency[%0d]: got %0d expected %0d", i, lat, (b_tab[i] == 6'd0) ? ZLAT : 12);
      end
      checks++; if (quotient !== q_tab[i] || remainder !== r_tab[i] || div_zero !== (b_tab[i] == 6'd0)) begin
        errors++; $display("[TB] FAIL extreme_result[%0d]: got q=%h r=%h dz=%b expected %h %h %b",
                           i, quotient, remainder, div_zero, q_tab[i], r_tab[i], b_tab[i] == 6'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    offer(12'd3000, 6'd45);
    in_valid = 1'b1; dividend = 12'd1; divisor = 6'd1;
    wait_result(lat);
    checks++; if (lat != 12) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 12", lat); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || quotient !== 12'd66 || remainder !== 6'd30 || in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_hold[%0d]: got ov=%b q=%0d r=%0d ir=%b expected 1 66 30 0",
                           i, out_valid, quotient, remainder, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    out_ready = 1'b0;
    offer(12'd1234, 6'd17);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_reset: got ir=%b ov=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    out_ready = 1'b1;
    offer(12'd63, 6'd9);
    wait_result(lat);
    checks++; if (lat != 12 || quotient !== 12'd7 || remainder !== 6'd0) begin
      errors++; $display("[TB] FAIL midrun_next: got lat=%0d q=%0d r=%0d expected 12 7 0", lat, quotient, remainder);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [5:0]  b;
    logic [11:0] eq;
    logic [5:0]  er;
    int lat;
    int waited;
    bit taken;
    for (int n = 0; n < 80; n++) begin
      a  = 12'($urandom_range(0, 4095));
      b  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      eq = ref_q(a, b);
      er = ref_r(a, b);
      offer(a, b);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = 12'($urandom);
        divisor  = 6'($urandom);
        step();
        lat++;
      end
      in_valid = 1'b0;
      checks++; if (lat != ((b == 6'd0) ? ZLAT : 12)) begin
        errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, (b == 6'd0) ? ZLAT : 12);
      end
      checks++; if (quotient !== eq || remainder !== er || div_zero !== (b == 6'd0)) begin
        errors++; $display("[TB] FAIL rand_result[%0d] %0d/%0d: got q=%0d r=%0d dz=%b expected %0d %0d %b",
                           n, a, b, quotient, remainder, div_zero, eq, er, b == 6'd0);
      end
      if (b != 6'd0) begin
        checks++;
        if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
          errors++; $display("[TB] FAIL rand_identity[%0d]: got q*d+r=%0d r=%0d expected %0d with r<%0d",
                             n, int'(quotient) * int'(b) + int'(remainder), remainder, a, b);
        end
      end
      taken = 1'b0;
      waited = 0;
      while (!taken) begin
        out_ready = (waited >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        waited++;
        if (out_ready) begin
          taken = 1'b1;
        end else begin
          checks++; if (out_valid !== 1'b1 || quotient !== eq || remainder !== er) begin
            errors++; $display("[TB] FAIL rand_hold[%0d]: got ov=%b q=%0d r=%0d expected 1 %0d %0d",
                               n, out_valid, quotient, remainder, eq, er);
          end
        end
      end
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL rand_in_ready[%0d]: got %b expected 1", n, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
